// File: rtl/l1_refill_ctrl.sv
// L1 miss refill controller: fetches a 4-word block from main memory,
// delivers it to the L1 array and stalls the CPU until the line hits.
module l1_refill_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_rd,
    input  logic [31:0]  cpu_addr,
    input  logic         l1_hit,
    output logic [31:0]  l1_addr,
    output logic         l1_delivered,
    output logic [127:0] l1_block,
    output logic         stall,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_gnt,
    input  logic         mem_beat_valid,
    input  logic [31:0]  mem_beat_data,
    output logic         err,
    output logic [15:0]  miss_count
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        DELIV,
        CHECK
    } state_t;

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYC - 1);

    state_t       state;
    state_t       state_nxt;
    logic [31:0]  miss_addr;
    logic [1:0]   beat;
    logic [9:0]   timer;
    logic [95:0]  fill_buf;
    logic         miss;
    logic         start;
    logic         progress;
    logic         expire;
    logic         beat_acc;

    assign miss     = cpu_rd && !l1_hit;
    assign beat_acc = (state == FILL) && mem_beat_valid;
    assign mem_addr = {miss_addr[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        stall        = 1'b1;
        mem_req      = 1'b0;
        l1_delivered = 1'b0;
        l1_addr      = miss_addr;
        start        = 1'b0;
        progress     = 1'b0;
        expire       = 1'b0;
        unique case (state)
            IDLE: begin
                l1_addr = cpu_addr;
                stall   = miss;
                if (miss) begin
                    start     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    progress  = 1'b1;
                    state_nxt = FILL;
                end else if (timer == TMO_LAST) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FILL: begin
                if (mem_beat_valid) begin
                    progress = 1'b1;
                    if (beat == 2'd3) begin
                        state_nxt = DELIV;
                    end
                end else if (timer == TMO_LAST) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DELIV: begin
                l1_delivered = 1'b1;
                state_nxt    = CHECK;
            end
            CHECK: begin
                if (l1_hit) begin
                    state_nxt = IDLE;
                end else begin
                    start     = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_addr  <= '0;
            miss_count <= '0;
            timer      <= '0;
            beat       <= '0;
            fill_buf   <= '0;
            l1_block   <= '0;
            err        <= 1'b0;
        end else begin
            if (state == IDLE && miss) begin
                miss_addr <= cpu_addr;
            end
            if (start && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
            // Timer measures silence from memory, not total refill time
            if (start || progress || expire) begin
                timer <= '0;
            end else if (state == REQ || state == FILL) begin
                timer <= timer + 10'd1;
            end
            if (state == REQ && mem_gnt) begin
                beat <= '0;
            end else if (beat_acc) begin
                beat <= beat + 2'd1;
            end
            if (expire) begin
                fill_buf <= '0;
            end else if (beat_acc) begin
                unique case (beat)
                    2'd0: fill_buf[31:0]  <= mem_beat_data;
                    2'd1: fill_buf[63:32] <= mem_beat_data;
                    2'd2: fill_buf[95:64] <= mem_beat_data;
                    2'd3: l1_block <= {mem_beat_data, fill_buf};
                    default: ;
                endcase
            end
            if (expire) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed bench for l1_refill_ctrl: normal refill, hits, gapped beats,
// re-refill on CHECK miss, timeout with sticky err, and mid-fill reset.
module tb_l1_refill_ctrl;

    logic         clk;
    logic         rst;
    logic         cpu_rd;
    logic [31:0]  cpu_addr;
    logic         l1_hit;
    logic [31:0]  l1_addr;
    logic         l1_delivered;
    logic [127:0] l1_block;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_beat_valid;
    logic [31:0]  mem_beat_data;
    logic         err;
    logic [15:0]  miss_count;

    int checks;
    int errors;
    int stall_n;
    int deliv_n;
    int mreq_n;
    int base;

    l1_refill_ctrl #(.TIMEOUT_CYC(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_rd         (cpu_rd),
        .cpu_addr       (cpu_addr),
        .l1_hit         (l1_hit),
        .l1_addr        (l1_addr),
        .l1_delivered   (l1_delivered),
        .l1_block       (l1_block),
        .stall          (stall),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_beat_valid (mem_beat_valid),
        .mem_beat_data  (mem_beat_data),
        .err            (err),
        .miss_count     (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: tally outputs of the settled cycle, then step past the edge
    task automatic cyc();
        #1;
        if (stall) stall_n++;
        if (l1_delivered) deliv_n++;
        if (mem_req) mreq_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
        mem_beat_valid = 1'b1;
        mem_beat_data = d0; cyc();
        mem_beat_data = d1; cyc();
        mem_beat_data = d2; cyc();
        mem_beat_data = d3; cyc();
        mem_beat_valid = 1'b0;
        mem_beat_data = '0;
    endtask

    initial begin
        checks = 0; errors = 0;
        stall_n = 0; deliv_n = 0; mreq_n = 0;
        rst = 1'b1; cpu_rd = 1'b0; cpu_addr = '0; l1_hit = 1'b0;
        mem_gnt = 1'b0; mem_beat_valid = 1'b0; mem_beat_data = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_count", miss_count, 16'd0);
        chk("rst_block", l1_block, 128'd0);
        chk("rst_deliv", l1_delivered, 1'b0);
        rst = 1'b0;
        cyc();

        // Basic miss, immediate grant, back-to-back beats
        stall_n = 0; deliv_n = 0;
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0047; l1_hit = 1'b0;
        #1;
        chk("s1_idle_stall", stall, 1'b1);
        chk("s1_idle_addr", l1_addr, 32'h0000_0047);
        chk("s1_idle_nreq", mem_req, 1'b0);
        cyc();
        mem_gnt = 1'b1;
        #1;
        chk("s1_req", mem_req, 1'b1);
        chk("s1_mem_addr", mem_addr, 32'h0000_0044);
        chk("s1_count", miss_count, 16'd1);
        chk("s1_l1_addr", l1_addr, 32'h0000_0047);
        cyc();
        mem_gnt = 1'b0;
        beats(32'h11, 32'h22, 32'h33, 32'h44);
        chk("s1_deliv", l1_delivered, 1'b1);
        chk("s1_block", l1_block, {32'h44, 32'h33, 32'h22, 32'h11});
        chk("s1_deliv_nreq", mem_req, 1'b0);
        l1_hit = 1'b1;
        cyc();
        chk("s1_check_deliv", l1_delivered, 1'b0);
        chk("s1_check_stall", stall, 1'b1);
        cyc();
        chk("s1_idle_hit", stall, 1'b0);
        chk("s1_stall_cycles", stall_n, 8);
        chk("s1_deliv_pulses", deliv_n, 1);
        chk("s1_block_hold", l1_block, {32'h44, 32'h33, 32'h22, 32'h11});

        // Hits never touch memory
        base = mreq_n;
        cpu_addr = 32'h0000_1230;
        repeat (3) cyc();
        chk("s2_stall", stall, 1'b0);
        chk("s2_no_req", mreq_n, base);
        chk("s2_count", miss_count, 16'd1);
        chk("s2_l1_addr", l1_addr, 32'h0000_1230);

        // Gapped beats with a stray beat while waiting for grant
        deliv_n = 0;
        cpu_addr = 32'h0000_0100; l1_hit = 1'b0;
        cyc();
        mem_beat_valid = 1'b1; mem_beat_data = 32'hDEAD_BEEF;
        mem_gnt = 1'b1;
        mem_gnt = 1'b0;
        cyc();
        chk("s3_req_hold", mem_req, 1'b1);
        chk("s3_req_addr", mem_addr, 32'h0000_0100);
        mem_beat_valid = 1'b0;
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (3) cyc();
            mem_beat_valid = 1'b1;
            mem_beat_data = 32'hA000_0000 + 32'(k);
            cyc();
            mem_beat_valid = 1'b0;
        end
        #1;
        chk("s3_deliv", l1_delivered, 1'b1);
        chk("s3_block", l1_block,
            {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
        chk("s3_no_err", err, 1'b0);
        l1_hit = 1'b1;
        cyc(); cyc();
        chk("s3_count", miss_count, 16'd2);
        chk("s3_idle", stall, 1'b0);
        cpu_rd = 1'b0;

        // CHECK still misses: second request, count bumps again
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0300; l1_hit = 1'b0;
        cyc();
        mem_gnt = 1'b1; cyc(); mem_gnt = 1'b0;
        beats(32'h1, 32'h2, 32'h3, 32'h4);
        cyc();
        chk("s5_check_stall", stall, 1'b1);
        cyc();
        chk("s5_rereq", mem_req, 1'b1);
        chk("s5_count", miss_count, 16'd4);
        chk("s5_l1_addr", l1_addr, 32'h0000_0300);
        mem_gnt = 1'b1; cyc(); mem_gnt = 1'b0;
        beats(32'h5, 32'h6, 32'h7, 32'h8);
        chk("s5_block", l1_block, {32'h8, 32'h7, 32'h6, 32'h5});
        l1_hit = 1'b1;
        cyc(); cyc();
        cpu_rd = 1'b0;

        // Grant withheld: abandon after 64 silent cycles
        deliv_n = 0;
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0400; l1_hit = 1'b0;
        cyc();
        repeat (63) cyc();
        chk("s6_req_before", mem_req, 1'b1);
        chk("s6_err_before", err, 1'b0);
        cyc();
        cpu_rd = 1'b0;
        #1;
        chk("s6_req_drop", mem_req, 1'b0);
        chk("s6_err", err, 1'b1);
        chk("s6_idle", stall, 1'b0);
        chk("s6_no_deliv", deliv_n, 0);
        chk("s6_count", miss_count, 16'd5);
        cyc();

        // Misses after err are still serviced and err stays set
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0500; l1_hit = 1'b0;
        cyc();
        mem_gnt = 1'b1; cyc(); mem_gnt = 1'b0;
        beats(32'h51, 32'h52, 32'h53, 32'h54);
        chk("s7_deliv", l1_delivered, 1'b1);
        chk("s7_block", l1_block, {32'h54, 32'h53, 32'h52, 32'h51});
        chk("s7_err_sticky", err, 1'b1);
        l1_hit = 1'b1;
        cyc(); cyc();
        cpu_rd = 1'b0;

        // Reset after two beats, then the held miss refills from beat 0
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0200; l1_hit = 1'b0;
        cyc();
        mem_gnt = 1'b1; cyc(); mem_gnt = 1'b0;
        mem_beat_valid = 1'b1;
        mem_beat_data = 32'hAA; cyc();
        mem_beat_data = 32'hBB; cyc();
        mem_beat_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("s4_rst_req", mem_req, 1'b0);
        chk("s4_rst_deliv", l1_delivered, 1'b0);
        chk("s4_rst_err", err, 1'b0);
        chk("s4_rst_count", miss_count, 16'd0);
        chk("s4_rst_block", l1_block, 128'd0);
        chk("s4_rst_stall", stall, 1'b1);
        chk("s4_rst_l1_addr", l1_addr, 32'h0000_0200);
        cyc();
        rst = 1'b0;
        cyc();
        chk("s4_req", mem_req, 1'b1);
        chk("s4_count", miss_count, 16'd1);
        chk("s4_mem_addr", mem_addr, 32'h0000_0200);
        mem_gnt = 1'b1; cyc(); mem_gnt = 1'b0;
        beats(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        chk("s4_deliv", l1_delivered, 1'b1);
        chk("s4_block", l1_block, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        l1_hit = 1'b1;
        cyc(); cyc();
        chk("s4_idle", stall, 1'b0);
        cpu_rd = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1_refill_ctrl.md
L1_REFILL_CTRL -- requirements
Module: l1_refill_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: cycles without memory progress before a refill is abandoned (legal 2..1023).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_rd  in  1  CPU read request valid this cycle.
REQ-005 cpu_addr  in  32  CPU word address ([31:5] tag, [4:2] set, [1:0] word).
REQ-006 l1_hit  in  1  hit flag from the L1 array for l1_addr.
REQ-007 l1_addr  out  32  address presented to L1 raddress.
REQ-008 l1_delivered  out  1  one-cycle pulse: l1_block valid for L1 write.
REQ-009 l1_block  out  128  assembled refill block, word k at bits [32k+31:32k].
REQ-010 stall  out  1  CPU must hold cpu_rd/cpu_addr while high.
REQ-011 mem_req  out  1  block-read request to main memory.
REQ-012 mem_addr  out  32  block-aligned miss address ({addr[31:2],2'b00}).
REQ-013 mem_gnt  in  1  memory accepts request (same-cycle handshake with mem_req).
REQ-014 mem_beat_valid  in  1  one 32-bit data beat valid.
REQ-015 mem_beat_data  in  32  beat data, beats ordered word 0..3.
REQ-016 err  out  1  sticky refill-timeout flag.
REQ-017 miss_count  out  16  saturating count of refills started.

Function
REQ-018 FSM states SHALL be IDLE, REQ, FILL, DELIV, CHECK.
REQ-019 IDLE: l1_addr = cpu_addr (pass-through); cpu_rd && !l1_hit -> latch cpu_addr into miss_addr, miss_count+1 (hold at 16'hFFFF), go REQ.
REQ-020 stall SHALL be combinational: 1 in IDLE when cpu_rd && !l1_hit, 1 in every non-IDLE state, else 0.
REQ-021 Outside IDLE l1_addr SHALL equal miss_addr.
REQ-022 REQ: mem_req=1, mem_addr from miss_addr, held stable until mem_gnt=1; mem_gnt -> FILL, beat counter=0.
REQ-023 FILL: each mem_beat_valid writes mem_beat_data into block word[beat counter], counter+1; beat 3 accepted -> DELIV.
REQ-024 mem_beat_valid outside FILL and mem_gnt outside REQ SHALL be ignored.
REQ-025 DELIV: l1_delivered=1 for exactly one cycle with full block on l1_block; -> CHECK.
REQ-026 CHECK: l1_hit=1 -> IDLE (stall drops next cycle); l1_hit=0 -> REQ (re-refill, miss_count+1).
REQ-027 Minimum miss latency: miss cycle + 1 REQ + 4 FILL + 1 DELIV + 1 CHECK = stall high 8 cycles with immediate gnt and back-to-back beats.
REQ-028 Progress timer SHALL reset on entry to REQ, on mem_gnt and on every accepted beat; increments each other cycle in REQ/FILL.
REQ-029 Timer reaching TIMEOUT_CYC SHALL set err, discard partial block, go IDLE without l1_delivered.
REQ-030 err SHALL clear only on rst; further misses after err are still serviced.
REQ-031 l1_block SHALL hold its last value outside DELIV; l1_delivered=0 in all other states.
REQ-032 mem_req SHALL be 0 in all states except REQ.

Reset
REQ-033 rst asserted (any state, including mid-FILL) SHALL immediately force IDLE, stall=0 (unless IDLE miss condition), mem_req=0, l1_delivered=0, err=0, miss_count=0, beat counter=0, timer=0, l1_block=0, miss_addr=0.
REQ-034 After rst deasserts, a pending cpu_rd miss SHALL start a new refill from REQ-019.

Verification
REQ-035 cpu_rd=1, cpu_addr=32'h0000_0047, l1_hit=0, gnt immediate, beats 11,22,33,44 -> mem_addr=32'h0000_0044, l1_block=128'h44..33..22..11 (word0=32'h11), one l1_delivered pulse, stall high 8 cycles, miss_count=1.
REQ-036 cpu_rd=1 with l1_hit=1 -> stall=0, mem_req never asserted, miss_count unchanged.
REQ-037 Miss, mem_gnt withheld 64 cycles (TIMEOUT_CYC=64) -> err=1, mem_req drops, state IDLE, no l1_delivered.
REQ-038 Beats with 3-cycle gaps and a stray beat during REQ -> stray ignored, block words in order, no timeout.
REQ-039 rst pulsed after 2 of 4 beats -> all outputs at reset values; next miss refills from beat 0 with correct block.
REQ-040 CHECK with l1_hit=0 -> second mem_req issued, miss_count=2; 65536+ misses -> miss_count saturates at 16'hFFFF.
